// File: rtl/mult32x32_pkg.sv
// Shared types and widths for the mult32x32 request interface block:
// FSM state encoding, datapath widths and the debug view struct.
package mult32x32_pkg;

   localparam int OPERAND_W = 32;
   localparam int PRODUCT_W = 64;
   localparam int CNT_W     = 16;
   localparam int WD_W      = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   typedef struct packed {
      state_t            state;
      logic [WD_W-1:0]   wd_count;
   } dbg_t;

endpackage

// File: rtl/mult32x32_req_if_if.sv
// Bus bundle between producer, multiplier datapath/FSM and consumer.
// slave = the request block's view, master = the surrounding system's view.
interface mult32x32_req_if_if;
   import mult32x32_pkg::*;

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both 1; payload must be stable while valid is high and not yet accepted.
   logic                 in_valid;
   logic                 in_ready;
   logic [OPERAND_W-1:0] in_a;
   logic [OPERAND_W-1:0] in_b;
   logic                 mult_start;
   logic [OPERAND_W-1:0] mult_a;
   logic [OPERAND_W-1:0] mult_b;
   logic                 mult_busy;
   logic [PRODUCT_W-1:0] mult_product;
   logic                 out_valid;
   logic                 out_ready;
   logic [PRODUCT_W-1:0] out_prod;

   modport slave (
      input  in_valid, in_a, in_b, mult_busy, mult_product, out_ready,
      output in_ready, mult_start, mult_a, mult_b, out_valid, out_prod
   );

   modport master (
      output in_valid, in_a, in_b, mult_busy, mult_product, out_ready,
      input  in_ready, mult_start, mult_a, mult_b, out_valid, out_prod
   );

endinterface

// File: rtl/mult32x32_watchdog.sv
// Cycle counter bounding how long the multiplier may stay busy; tc flags the
// last allowed busy cycle so the caller can abort on that edge.
module mult32x32_watchdog
   import mult32x32_pkg::*;
#(
   parameter int LIMIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   output logic            tc,
   output logic [WD_W-1:0] count
);

   localparam logic [WD_W-1:0] LAST = WD_W'(LIMIT - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 1'b1;
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/mult32x32_req_if.sv
// Request/response wrapper around an external 32x32 multiplier FSM.
// Define MULT_REQ_IF_STATS_EN to add the op_count / fast_count statistics ports.
// The multiplier FSM is expected to be reset from ~reset at the top level.
module mult32x32_req_if
   import mult32x32_pkg::*;
#(
   parameter int WATCHDOG_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   mult32x32_req_if_if.slave     bus,
   output logic                  err,
   output dbg_t                  dbg
`ifdef MULT_REQ_IF_STATS_EN
   ,
   output logic [CNT_W-1:0]      op_count,
   output logic [CNT_W-1:0]      fast_count
`endif
);

   state_t          state_q;
   state_t          state_d;
   logic            wd_tc;
   logic [WD_W-1:0] wd_count;
   logic            accept;
   logic            capture;
   logic            timeout;

   assign accept  = (state_q == S_IDLE) && bus.in_valid;
   assign capture = (state_q == S_RUN) && !bus.mult_busy;
   assign timeout = (state_q == S_RUN) && bus.mult_busy && wd_tc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.in_valid) state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            if (!bus.mult_busy) state_d = S_HOLD;
            else if (wd_tc)     state_d = S_IDLE;
         end
         S_HOLD:   if (bus.out_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready   = (state_q == S_IDLE);
      bus.mult_start = (state_q == S_LAUNCH);
      bus.out_valid  = (state_q == S_HOLD);
   end

   // Operands hold from accept until the next accept, covering LAUNCH..capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.mult_a   <= '0;
         bus.mult_b   <= '0;
         bus.out_prod <= '0;
         err          <= 1'b0;
      end else begin
         if (accept) begin
            bus.mult_a <= bus.in_a;
            bus.mult_b <= bus.in_b;
         end
         if (capture) bus.out_prod <= bus.mult_product;
         if (timeout) err <= 1'b1;
      end
   end

   mult32x32_watchdog #(
      .LIMIT (WATCHDOG_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == S_LAUNCH),
      .enable ((state_q == S_RUN) && bus.mult_busy),
      .tc     (wd_tc),
      .count  (wd_count)
   );

   assign dbg.state    = state_q;
   assign dbg.wd_count = wd_count;

`ifdef MULT_REQ_IF_STATS_EN
   // At capture the watchdog count equals the number of busy cycles seen in RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_count   <= '0;
         fast_count <= '0;
      end else begin
         if ((state_q == S_HOLD) && bus.out_ready) op_count <= op_count + 1'b1;
         if (capture && (wd_count == WD_W'(1)))    fast_count <= fast_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mult32x32_req_if.sv
// Directed bench for mult32x32_req_if with a behavioural multiplier FSM model
// (1 busy cycle when both MSWs are zero, else 4; overridable for timeouts).
module tb_mult32x32_req_if;
   import mult32x32_pkg::*;

   logic clk;
   logic reset;
   logic err;
   dbg_t dbg;
`ifdef MULT_REQ_IF_STATS_EN
   logic [CNT_W-1:0] op_count;
   logic [CNT_W-1:0] fast_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int busy_ovr = 0;

   mult32x32_req_if_if bus();

   mult32x32_req_if #(.WATCHDOG_CYCLES(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .err        (err),
      .dbg        (dbg)
`ifdef MULT_REQ_IF_STATS_EN
      ,
      .op_count   (op_count),
      .fast_count (fast_count)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // multiplier FSM model, reset from the inverted block reset
   logic        mrst;
   logic [7:0]  left;
   logic [63:0] prod;
   assign mrst = ~reset;
   always_ff @(posedge clk or posedge mrst) begin
      if (mrst) begin
         left <= '0;
         prod <= '0;
      end else if (bus.mult_start) begin
         if (busy_ovr != 0) left <= 8'(busy_ovr);
         else if (bus.mult_a[31:16] == 16'h0 && bus.mult_b[31:16] == 16'h0) left <= 8'd1;
         else left <= 8'd4;
         prod <= 64'(bus.mult_a) * 64'(bus.mult_b);
      end else if (left != 0) begin
         left <= left - 1'b1;
      end
   end
   assign bus.mult_busy    = (left != 0);
   assign bus.mult_product = prod;

   // driver tasks
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string name);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL %s ready_before: got %b want 1", name, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.mult_start !== 1'b1 || dbg.state !== S_LAUNCH) begin
         n_bad++; $display("FAIL %s launch: start=%b state=%0d want 1/%0d", name, bus.mult_start, dbg.state, S_LAUNCH);
      end
   endtask

   // Counts edges after the accept edge; cycle 3+busy counting accept cycle as 0.
   task automatic wait_valid(input int exp_edges, input logic [63:0] exp_prod, input string name);
      int  edges = 0;
      bit  found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.out_valid === 1'b1) found = 1;
      end
      n_cmp++;
      if (!found || edges != exp_edges) begin
         n_bad++; $display("FAIL %s latency: got %0d edges (found=%0d) want %0d", name, edges, found, exp_edges);
      end
      n_cmp++;
      if (bus.out_prod !== exp_prod) begin
         n_bad++; $display("FAIL %s prod: got %h want %h", name, bus.out_prod, exp_prod);
      end
   endtask

   task automatic finish_op(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg.state !== S_IDLE) begin
         n_bad++; $display("FAIL %s handshake: valid=%b ready=%b state=%0d want 0/1/0", name, bus.out_valid, bus.in_ready, dbg.state);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_edges,
                         input logic [63:0] exp_prod, input string name);
      start_op(a, b, name);
      wait_valid(exp_edges, exp_prod, name);
      finish_op(name);
   endtask

   // tests
   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.mult_start !== 1'b0 || bus.mult_a !== 32'h0 || bus.mult_b !== 32'h0 ||
          bus.out_valid !== 1'b0 || bus.out_prod !== 64'h0 || err !== 1'b0 ||
          dbg.state !== S_IDLE || dbg.wd_count !== 8'h0) begin
         n_bad++; $display("FAIL reset_values: start=%b a=%h b=%h v=%b p=%h err=%b st=%0d wd=%0d want all 0",
                           bus.mult_start, bus.mult_a, bus.mult_b, bus.out_valid, bus.out_prod, err, dbg.state, dbg.wd_count);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_small();
      start_op(32'h0000_1234, 32'h0000_0010, "small");
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.mult_start !== 1'b0 || bus.mult_a !== 32'h0000_1234 || bus.mult_b !== 32'h0000_0010) begin
         n_bad++; $display("FAIL small_start_pulse: start=%b a=%h b=%h want 0/00001234/00000010", bus.mult_start, bus.mult_a, bus.mult_b);
      end
      wait_valid(2, 64'h0000_0000_0001_2340, "small");
      finish_op("small");
   endtask

   task automatic test_large();
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 64'hFFFF_FFFE_0000_0001, "large");
   endtask

   task automatic test_ready_early();
      bus.out_ready = 1'b1;
      start_op(32'h0000_0100, 32'h0000_0003, "early");
      bus.out_ready = 1'b1;
      wait_valid(3, 64'h300, "early");
      finish_op("early");
   endtask

   task automatic test_hold_stall();
      start_op(32'd7, 32'd9, "stall");
      wait_valid(3, 64'd63, "stall");
      for (int i = 0; i < 5; i++) begin
         bus.out_ready = 1'b0;
         bus.in_valid = (i % 2 == 0);
         bus.in_a = 32'hDEAD_0000 + 32'(i);
         bus.in_b = 32'h0000_BEEF;
         @(posedge clk);
         #1;
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_prod !== 64'd63 || bus.in_ready !== 1'b0 || bus.mult_a !== 32'd7) begin
            n_bad++; $display("FAIL stall_hold%0d: v=%b p=%h rdy=%b a=%h want 1/63/0/7", i, bus.out_valid, bus.out_prod, bus.in_ready, bus.mult_a);
         end
      end
      bus.in_valid = 1'b0;
      finish_op("stall");
      n_cmp++;
      if (bus.mult_a !== 32'd7 || bus.mult_b !== 32'd9) begin
         n_bad++; $display("FAIL stall_no_latch: a=%h b=%h want 7/9", bus.mult_a, bus.mult_b);
      end
   endtask

   task automatic test_watchdog();
      int  first_err = 0;
      bit  saw_valid = 0;
      busy_ovr = 10;
      start_op(32'd1, 32'd2, "wdog");
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) saw_valid = 1;
         if (err === 1'b1 && first_err == 0) begin
            first_err = k;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
               n_bad++; $display("FAIL wdog_ready: got %b want 1", bus.in_ready);
            end
         end
      end
      busy_ovr = 0;
      n_cmp++;
      if (first_err != 9) begin
         n_bad++; $display("FAIL wdog_err_time: got edge %0d want 9", first_err);
      end
      n_cmp++;
      if (saw_valid) begin
         n_bad++; $display("FAIL wdog_no_valid: got out_valid=1 want 0");
      end
      run_op(32'd3, 32'd4, 3, 64'd12, "after_wdog");
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++; $display("FAIL wdog_sticky: got %b want 1", err);
      end
   endtask

   task automatic test_reset_mid();
      bit saw_valid = 0;
      start_op(32'h0001_0000, 32'd2, "rst_mid");
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.mult_start !== 1'b0 || bus.mult_a !== 32'h0 || bus.mult_b !== 32'h0 ||
          bus.out_valid !== 1'b0 || bus.out_prod !== 64'h0 || err !== 1'b0 || dbg.state !== S_IDLE) begin
         n_bad++; $display("FAIL rst_mid_clear: start=%b a=%h b=%h v=%b p=%h err=%b st=%0d want all 0",
                           bus.mult_start, bus.mult_a, bus.mult_b, bus.out_valid, bus.out_prod, err, dbg.state);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) saw_valid = 1;
      end
      n_cmp++;
      if (saw_valid || bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_abandon: saw_valid=%0d ready=%b want 0/1", saw_valid, bus.in_ready);
      end
      run_op(32'd3, 32'd5, 3, 64'd15, "rst_mid_next");
   endtask

`ifdef MULT_REQ_IF_STATS_EN
   task automatic test_stats();
      run_op(32'h0001_0000, 32'd1, 6, 64'h0001_0000, "stats_slow");
      run_op(32'd2, 32'd2, 3, 64'd4, "stats_fast");
      n_cmp++;
      if (op_count !== 16'd3 || fast_count !== 16'd2) begin
         n_bad++; $display("FAIL stats_counts: op=%0d fast=%0d want 3/2", op_count, fast_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_small();
      test_large();
      test_ready_early();
      test_hold_stall();
      test_watchdog();
      test_reset_mid();
`ifdef MULT_REQ_IF_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
